// File: rtl/jtframe_romload.sv
// HPS ioctl byte stream to SDRAM programming port bridge.
// Bytes are remapped at push time, queued in a small FIFO, then replayed as masked writes.
module jtframe_romload #(
    parameter int unsigned FIFO_AW       = 2,
    parameter logic [21:0] REGION_START  = 22'h20_0000,
    parameter logic [21:0] REGION_OFFSET = 22'h10_0000
) (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic        downloading,
    input  logic [21:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    input  logic        ioctl_wr,
    output logic [21:0] prog_addr,
    output logic [7:0]  prog_data,
    output logic [1:0]  prog_mask,
    output logic        prog_we,
    input  logic        prog_rdy,
    output logic        dwnld_busy,
    output logic        overflow,
    output logic [21:0] byte_cnt
);

    localparam int unsigned      Depth       = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FullCnt     = Depth[FIFO_AW:0];
    // Byte-address shift for region 1: -REGION_START + 2*REGION_OFFSET, modulo 2^23
    localparam logic [22:0]      RegionShift = {REGION_OFFSET, 1'b0} - {1'b0, REGION_START};

    typedef enum logic [1:0] {StIdle, StLoad, StWrite, StGap} state_e;

    state_e             state_q;
    logic [21:0]        mem_addr [Depth];
    logic [7:0]         mem_data [Depth];
    logic               mem_odd  [Depth];
    logic [FIFO_AW-1:0] wr_ptr_q;
    logic [FIFO_AW-1:0] rd_ptr_q;
    logic [FIFO_AW:0]   cnt_q;
    logic               dl_q;

    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic               drop;
    logic               dl_rise;
    logic [22:0]        mapped;

    always_comb begin
        full       = (cnt_q == FullCnt);
        empty      = (cnt_q == '0);
        pop        = (state_q == StWrite) && prog_rdy;
        push       = ioctl_wr && downloading && (!full || pop);
        drop       = ioctl_wr && downloading && full && !pop;
        dl_rise    = downloading && !dl_q;
        mapped     = (ioctl_addr < REGION_START) ? {1'b0, ioctl_addr}
                                                 : {1'b0, ioctl_addr} + RegionShift;
        dwnld_busy = downloading || !empty || (state_q != StIdle);
    end

    // Storage needs no reset: occupancy is tracked by cnt_q alone.
    always_ff @(posedge clk_sys) begin
        if (push) begin
            mem_addr[wr_ptr_q] <= mapped[22:1];
            mem_data[wr_ptr_q] <= ioctl_data;
            mem_odd[wr_ptr_q]  <= mapped[0];
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      cnt_q <= cnt_q + 1'b1;
            else if (pop && !push) cnt_q <= cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            dl_q     <= 1'b0;
            byte_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            dl_q <= downloading;
            if (dl_rise) begin
                byte_cnt <= push ? 22'd1 : 22'd0;
                overflow <= drop;
            end else begin
                if (push) byte_cnt <= byte_cnt + 22'd1;
                if (drop) overflow <= 1'b1;
            end
        end
    end

    // The head entry stays in the FIFO until acknowledged; prog_* hold a copy of it.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state_q   <= StIdle;
            prog_we   <= 1'b0;
            prog_addr <= '0;
            prog_data <= '0;
            prog_mask <= 2'b11;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!empty) begin
                        prog_addr <= mem_addr[rd_ptr_q];
                        prog_data <= mem_data[rd_ptr_q];
                        prog_mask <= mem_odd[rd_ptr_q] ? 2'b01 : 2'b10;
                        state_q   <= StLoad;
                    end
                end
                StLoad: begin
                    prog_we <= 1'b1;
                    state_q <= StWrite;
                end
                StWrite: begin
                    if (prog_rdy) begin
                        prog_we <= 1'b0;
                        state_q <= StGap;
                    end
                end
                StGap: begin
                    if (!empty) begin
                        prog_addr <= mem_addr[rd_ptr_q];
                        prog_data <= mem_data[rd_ptr_q];
                        prog_mask <= mem_odd[rd_ptr_q] ? 2'b01 : 2'b10;
                        prog_we   <= 1'b1;
                        state_q   <= StWrite;
                    end else begin
                        state_q <= StIdle;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtframe_romload.sv
// Bench for jtframe_romload: scoreboard of expected SDRAM writes checked as each write starts.
module tb_jtframe_romload;

    localparam int unsigned RegStart = 32'h20_0000;
    localparam int unsigned RegOff   = 32'h10_0000;

    logic        clk_sys = 1'b0;
    logic        rst;
    logic        downloading;
    logic [21:0] ioctl_addr;
    logic [7:0]  ioctl_data;
    logic        ioctl_wr;
    logic [21:0] prog_addr;
    logic [7:0]  prog_data;
    logic [1:0]  prog_mask;
    logic        prog_we;
    logic        prog_rdy;
    logic        dwnld_busy;
    logic        overflow;
    logic [21:0] byte_cnt;

    jtframe_romload dut (
        .clk_sys     (clk_sys),
        .rst         (rst),
        .downloading (downloading),
        .ioctl_addr  (ioctl_addr),
        .ioctl_data  (ioctl_data),
        .ioctl_wr    (ioctl_wr),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .prog_mask   (prog_mask),
        .prog_we     (prog_we),
        .prog_rdy    (prog_rdy),
        .dwnld_busy  (dwnld_busy),
        .overflow    (overflow),
        .byte_cnt    (byte_cnt)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct packed {
        logic [21:0] addr;
        logic [7:0]  data;
        logic [1:0]  mask;
    } wr_t;

    int   checks   = 0;
    int   errors   = 0;
    wr_t  sb_q[$];
    wr_t  cur;
    wr_t  obs;
    int   n_writes = 0;
    int   low_run  = 0;
    int   wcyc     = 0;
    int   rdy_lat  = 0;
    bit   mon_en   = 1'b0;
    bit   gap_check = 1'b0;
    bit   rdy_en   = 1'b0;
    bit   ack_req  = 1'b0;
    logic we_prev  = 1'b0;

    function automatic wr_t model(input logic [21:0] a, input logic [7:0] d);
        int unsigned ap;
        wr_t w;
        if (a < RegStart) ap = a;
        else ap = a - RegStart + 2 * RegOff;
        w.addr = 22'(ap >> 1);
        w.data = d;
        w.mask = ap[0] ? 2'b01 : 2'b10;
        return w;
    endfunction

    // Write monitor: compares each new write with the scoreboard head and checks hold stability.
    initial begin
        forever begin
            @(negedge clk_sys);
            if (mon_en) begin
                obs.addr = prog_addr;
                obs.data = prog_data;
                obs.mask = prog_mask;
                if (prog_we === 1'b1 && we_prev !== 1'b1) begin
                    n_writes++;
                    if (gap_check) begin
                        checks++;
                        if (low_run !== 1) begin
                            errors++;
                            $display("FAIL write_gap: got %0d cycles low, want 1", low_run);
                        end
                    end
                    checks++;
                    if (sb_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_write: got addr %h data %h, want no write",
                                 prog_addr, prog_data);
                        cur = obs;
                    end else begin
                        cur = sb_q.pop_front();
                        if (obs !== cur) begin
                            errors++;
                            $display("FAIL write_content: got a=%h d=%h m=%b, want a=%h d=%h m=%b",
                                     obs.addr, obs.data, obs.mask, cur.addr, cur.data, cur.mask);
                        end
                    end
                    low_run = 0;
                end else if (prog_we === 1'b1) begin
                    checks++;
                    if (obs !== cur) begin
                        errors++;
                        $display("FAIL write_hold: got a=%h d=%h m=%b, want a=%h d=%h m=%b",
                                 obs.addr, obs.data, obs.mask, cur.addr, cur.data, cur.mask);
                    end
                end else begin
                    low_run++;
                end
                we_prev = prog_we;
            end
        end
    end

    // SDRAM ack model: automatic ack rdy_lat cycles into a write, or a one-shot manual ack.
    initial begin
        prog_rdy = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (prog_rdy) begin
                prog_rdy = 1'b0;
                wcyc     = 0;
            end else if (ack_req) begin
                prog_rdy = 1'b1;
            end else if (rdy_en && prog_we === 1'b1) begin
                if (wcyc == rdy_lat) prog_rdy = 1'b1;
                else wcyc++;
            end else begin
                wcyc = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, want finish before timeout");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk_sys);
        #2;
    endtask

    task automatic strobe(input logic [21:0] a, input logic [7:0] d, input bit accept);
        ioctl_addr = a;
        ioctl_data = d;
        ioctl_wr   = 1'b1;
        if (accept) sb_q.push_back(model(a, d));
        tick();
        ioctl_wr = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 1'b0;
        downloading = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_sys);
            if (dwnld_busy === 1'b0) begin
                done = 1'b1;
                break;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_drain: got busy after 200 cycles, want idle", name);
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL %s_pending: got %0d writes missing, want 0", name, sb_q.size());
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        downloading = 1'b1;
        tick();
        tick();
        checks++;
        if (prog_we !== 1'b0 || prog_addr !== 22'd0 || prog_data !== 8'd0 ||
            prog_mask !== 2'b11) begin
            errors++;
            $display("FAIL reset_prog: got we=%b a=%h d=%h m=%b, want 0 0 0 11",
                     prog_we, prog_addr, prog_data, prog_mask);
        end
        checks++;
        if (overflow !== 1'b0 || byte_cnt !== 22'd0) begin
            errors++;
            $display("FAIL reset_stats: got ovf=%b cnt=%0d, want 0 0", overflow, byte_cnt);
        end
        checks++;
        if (dwnld_busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_busy_dl: got %b, want 1", dwnld_busy);
        end
        downloading = 1'b0;
        #1;
        checks++;
        if (dwnld_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy_idle: got %b, want 0", dwnld_busy);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        int hi;
        rdy_en = 1'b1;
        rdy_lat = 3;
        downloading = 1'b1;
        tick();
        strobe(22'h00_0005, 8'hA5, 1'b1);
        @(negedge clk_sys);
        checks++;
        if (prog_we !== 1'b0) begin
            errors++;
            $display("FAIL latency_n1: got we=%b, want 0", prog_we);
        end
        @(negedge clk_sys);
        checks++;
        if (prog_we !== 1'b0) begin
            errors++;
            $display("FAIL latency_n2: got we=%b, want 0", prog_we);
        end
        @(negedge clk_sys);
        checks++;
        if (prog_we !== 1'b1) begin
            errors++;
            $display("FAIL latency_n3: got we=%b, want 1", prog_we);
        end
        downloading = 1'b0;
        hi = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_sys);
            if (prog_we === 1'b1) hi++;
            else break;
        end
        checks++;
        if (hi != 4) begin
            errors++;
            $display("FAIL we_width: got %0d cycles high, want 4", hi);
        end
        checks++;
        if (dwnld_busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_gap: got %b, want 1", dwnld_busy);
        end
        @(negedge clk_sys);
        checks++;
        if (dwnld_busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_after_gap: got %b, want 0", dwnld_busy);
        end
        checks++;
        if (byte_cnt !== 22'd1) begin
            errors++;
            $display("FAIL single_cnt: got %0d, want 1", byte_cnt);
        end
        tick();
    endtask

    task automatic test_relocation();
        rdy_en = 1'b1;
        rdy_lat = 0;
        downloading = 1'b1;
        tick();
        strobe(22'h20_0003, 8'h3C, 1'b1);
        strobe(22'h1F_FFFE, 8'hC3, 1'b1);
        strobe(22'h3F_FFFF, 8'h5A, 1'b1);
        wait_idle("reloc");
        checks++;
        if (byte_cnt !== 22'd3) begin
            errors++;
            $display("FAIL reloc_cnt: got %0d, want 3", byte_cnt);
        end
    endtask

    task automatic test_overflow_full_pop();
        int nw;
        rdy_en = 1'b0;
        downloading = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) strobe(22'(16 + i), 8'(8'h10 + i), i < 4);
        tick();
        checks++;
        if (overflow !== 1'b1 || byte_cnt !== 22'd4) begin
            errors++;
            $display("FAIL overflow: got ovf=%b cnt=%0d, want 1 4", overflow, byte_cnt);
        end
        checks++;
        if (prog_we !== 1'b1) begin
            errors++;
            $display("FAIL stall_we: got %b, want 1", prog_we);
        end
        // Restart the download while the FIFO is still full
        downloading = 1'b0;
        tick();
        downloading = 1'b1;
        tick();
        checks++;
        if (overflow !== 1'b0 || byte_cnt !== 22'd0) begin
            errors++;
            $display("FAIL new_download: got ovf=%b cnt=%0d, want 0 0", overflow, byte_cnt);
        end
        checks++;
        if (prog_we !== 1'b1) begin
            errors++;
            $display("FAIL no_flush: got we=%b, want 1", prog_we);
        end
        ack_req = 1'b1;
        strobe(22'h00_0101, 8'h77, 1'b1);
        ack_req = 1'b0;
        rdy_lat = 0;
        rdy_en = 1'b1;
        gap_check = 1'b1;
        nw = n_writes;
        checks++;
        if (overflow !== 1'b0 || byte_cnt !== 22'd1) begin
            errors++;
            $display("FAIL full_pop: got ovf=%b cnt=%0d, want 0 1", overflow, byte_cnt);
        end
        wait_idle("drain");
        gap_check = 1'b0;
        checks++;
        if (n_writes - nw != 4) begin
            errors++;
            $display("FAIL drain_count: got %0d writes, want 4", n_writes - nw);
        end
    endtask

    task automatic test_reset_mid();
        int nw;
        rdy_en = 1'b0;
        downloading = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) strobe(22'(64 + i), 8'(8'hE0 + i), 1'b1);
        for (int i = 0; i < 10; i++) begin
            if (prog_we === 1'b1) break;
            tick();
        end
        checks++;
        if (prog_we !== 1'b1) begin
            errors++;
            $display("FAIL rmid_write: got we=%b, want 1", prog_we);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (prog_we !== 1'b0 || prog_addr !== 22'd0 || prog_data !== 8'd0 ||
            prog_mask !== 2'b11) begin
            errors++;
            $display("FAIL rmid_prog: got we=%b a=%h d=%h m=%b, want 0 0 0 11",
                     prog_we, prog_addr, prog_data, prog_mask);
        end
        checks++;
        if (overflow !== 1'b0 || byte_cnt !== 22'd0 || dwnld_busy !== 1'b1) begin
            errors++;
            $display("FAIL rmid_stats: got ovf=%b cnt=%0d busy=%b, want 0 0 1",
                     overflow, byte_cnt, dwnld_busy);
        end
        sb_q.delete();
        nw = n_writes;
        rdy_en = 1'b1;
        repeat (12) tick();
        checks++;
        if (n_writes != nw || prog_we !== 1'b0) begin
            errors++;
            $display("FAIL rmid_nowrite: got %0d writes we=%b, want 0 0", n_writes - nw, prog_we);
        end
        downloading = 1'b0;
        tick();
        checks++;
        if (dwnld_busy !== 1'b0) begin
            errors++;
            $display("FAIL rmid_busy: got %b, want 0", dwnld_busy);
        end
    endtask

    task automatic test_ignored();
        int nw;
        downloading = 1'b0;
        nw = n_writes;
        for (int i = 0; i < 3; i++) strobe(22'(128 + i), 8'(8'h90 + i), 1'b0);
        repeat (8) tick();
        checks++;
        if (n_writes != nw || byte_cnt !== 22'd0 || dwnld_busy !== 1'b0) begin
            errors++;
            $display("FAIL ignored: got %0d writes cnt=%0d busy=%b, want 0 0 0",
                     n_writes - nw, byte_cnt, dwnld_busy);
        end
    endtask

    initial begin
        rst = 1'b1;
        downloading = 1'b0;
        ioctl_wr = 1'b0;
        ioctl_addr = '0;
        ioctl_data = '0;
        test_reset();
        mon_en = 1'b1;
        test_single();
        test_relocation();
        test_overflow_full_pop();
        test_reset_mid();
        test_ignored();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
